// File: rtl/tq_pkg.sv
// Shared encodings for the toggle-cell bank: global mode codes and window FSM states.
package tq_pkg;

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_SC_ADD = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;
  localparam logic [1:0] MODE_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } win_state_e;

endpackage

// File: rtl/tq_bank_if.sv
// Control/data bundle of the toggle bank: master drives stimulus, slave is the bank.
interface tq_bank_if #(
  parameter int CH    = 4,
  parameter int CNT_W = 8
);
  logic                      en;
  logic [1:0]                mode;
  logic [CH-1:0]             T;
  logic [CH-1:0]             A;
  logic [CH-1:0]             B;
  logic [CH-1:0]             load;
  logic [CH-1:0]             load_val;
  logic                      start;
  logic [CH-1:0]             Q;
  logic [CH*(CNT_W+1)-1:0]   ones;
  logic                      busy;
  logic                      done;

  modport master (
    output en, mode, T, A, B, load, load_val, start,
    input  Q, ones, busy, done
  );

  modport slave (
    input  en, mode, T, A, B, load, load_val, start,
    output Q, ones, busy, done
  );
endinterface

// File: rtl/tq_cell.sv
// One channel: T flip-flop / stochastic scaled adder (Q, S) plus its 1s counter.
module tq_cell
  import tq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             t,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic             load_val,
  input  logic             clr_cnt,
  input  logic             cnt_en,
  output logic             q,
  output logic [CNT_W:0]   ones
);

  logic           q_q, q_d;
  logic           s_q, s_d;
  logic [CNT_W:0] ones_q, ones_d;

  always_comb begin
    q_d    = q_q;
    s_d    = s_q;
    ones_d = ones_q;
    if (en) begin
      if (load) begin
        q_d = load_val;
        s_d = load_val;
      end else begin
        case (mode)
          MODE_TOGGLE: begin
            q_d = q_q ^ t;
            s_d = q_q ^ t;
          end
          MODE_SC_ADD: begin
            // Equal operands pass through; differing ones alternate from S to give (A+B)/2.
            if (a == b) begin
              q_d = a;
            end else begin
              q_d = s_q;
              s_d = ~s_q;
            end
          end
          MODE_HOLD: ;
          default: begin
            q_d = 1'b0;
            s_d = 1'b0;
          end
        endcase
      end
    end
    // Counter samples the registered Q, i.e. the value before this edge's update.
    if (clr_cnt)     ones_d = '0;
    else if (cnt_en) ones_d = ones_q + {{CNT_W{1'b0}}, q_q};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q    <= 1'b0;
      s_q    <= 1'b0;
      ones_q <= '0;
    end else begin
      q_q    <= q_d;
      s_q    <= s_d;
      ones_q <= ones_d;
    end
  end

  assign q    = q_q;
  assign ones = ones_q;

endmodule

// File: rtl/tq_bank.sv
// CH toggle cells sharing one 2^CNT_W-sample measurement window for probability readout.
module tq_bank
  import tq_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = 8
) (
  input  logic      clk,
  input  logic      rst,
  tq_bank_if.slave  bus
);

  localparam logic [CNT_W:0] WIN_LAST = {1'b0, {CNT_W{1'b1}}};

  win_state_e              state_q, state_d;
  logic [CNT_W:0]          cnt_q, cnt_d;
  logic                    clr_cnt;
  logic                    cnt_en;
  logic [CH-1:0]           q_w;
  logic [CH-1:0][CNT_W:0]  ones_w;

  // Start handling is not gated by en; only counting is.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_cnt = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          clr_cnt = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.en) begin
          cnt_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == WIN_LAST) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_cell
    tq_cell #(.CNT_W(CNT_W)) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .mode     (bus.mode),
      .t        (bus.T[gi]),
      .a        (bus.A[gi]),
      .b        (bus.B[gi]),
      .load     (bus.load[gi]),
      .load_val (bus.load_val[gi]),
      .clr_cnt  (clr_cnt),
      .cnt_en   (cnt_en),
      .q        (q_w[gi]),
      .ones     (ones_w[gi])
    );
  end

  assign bus.Q    = q_w;
  assign bus.ones = ones_w;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);

endmodule
